alu_exec_unit: RTL and testbench

Parametrised successor to the single-cycle ALU command decoder. Decodes MIPS opcode/funct, executes the operation, and returns a registered result over a valid/ready handshake. Adds a wider op set, signed-overflow detection, and an iterative multiply/divide sequencer writing HI/LO. Sits in the EX stage between register read and writeback.

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for the EX-stage ALU.
// master = issuing stage, slave = alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [IMM_W-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wb_en;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, opcode, funct, rs_val, rt_val, imm, out_ready,
        input  in_ready, out_valid, result, wb_en, overflow, illegal
    );

    modport slave (
        input  in_valid, opcode, funct, rs_val, rt_val, imm, out_ready,
        output in_ready, out_valid, result, wb_en, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS EX-stage ALU with registered valid/ready result.
// Optional ALU_MULDIV_EN adds HI/LO and the iterative mult/div sequencer.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] w_a, w_b, w_simm, w_zimm, w_lui;
    logic [WIDTH-1:0] w_sum, w_dif, w_sumi, w_res;
    logic             w_ovf_add, w_ovf_sub, w_ovf_addi;
    logic             w_accept, w_in_ready, w_last;
    logic             w_wb, w_ovf, w_ill, w_mul, w_div;
    logic             r_out_valid, r_wb_en, r_overflow, r_illegal;
    logic [WIDTH-1:0] r_result;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_wh, r_wl, r_op;
    logic               r_qneg, r_rneg, w_sgn, w_sa, w_sb;
    logic [WIDTH-1:0]   w_ma, w_mb, w_nh, w_nl;
    logic [WIDTH:0]     w_madd, w_drem, w_ddif;
    logic [2*WIDTH-1:0] w_prod;
`endif

    assign w_a    = bus.rs_val;
    assign w_b    = bus.rt_val;
    assign w_simm = WIDTH'($signed(bus.imm));
    assign w_zimm = WIDTH'(bus.imm);
    assign w_lui  = WIDTH'(bus.imm) << (WIDTH - IMM_W);
    assign w_sum  = w_a + w_b;
    assign w_dif  = w_a - w_b;
    assign w_sumi = w_a + w_simm;

    assign w_ovf_add  = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_ovf_sub  = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                        (w_dif[WIDTH-1] != w_a[WIDTH-1]);
    assign w_ovf_addi = (w_a[WIDTH-1] == w_simm[WIDTH-1]) &&
                        (w_sumi[WIDTH-1] != w_a[WIDTH-1]);

    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.wb_en     = r_wb_en;
    assign bus.overflow  = r_overflow;
    assign bus.illegal   = r_illegal;

    // Opcode/funct decode and single-cycle result selection.
    always_comb begin
        w_res = '0;
        w_wb  = 1'b1;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        w_mul = 1'b0;
        w_div = 1'b0;
`ifdef ALU_MULDIV_EN
        w_sgn = 1'b0;
`endif
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20: begin
                        w_res = w_sum;
                        w_ovf = w_ovf_add;
                    end
                    6'h21: w_res = w_sum;
                    6'h22: begin
                        w_res = w_dif;
                        w_ovf = w_ovf_sub;
                    end
                    6'h23: w_res = w_dif;
                    6'h24: w_res = w_a & w_b;
                    6'h25: w_res = w_a | w_b;
                    6'h26: w_res = w_a ^ w_b;
                    6'h27: w_res = ~(w_a | w_b);
                    6'h2A: w_res = WIDTH'($signed(w_a) < $signed(w_b));
                    6'h2B: w_res = WIDTH'(w_a < w_b);
`ifdef ALU_MULDIV_EN
                    6'h10: w_res = r_hi;
                    6'h12: w_res = r_lo;
                    6'h18: begin
                        w_mul = 1'b1;
                        w_sgn = 1'b1;
                        w_wb  = 1'b0;
                    end
                    6'h19: begin
                        w_mul = 1'b1;
                        w_wb  = 1'b0;
                    end
                    6'h1A: begin
                        w_div = 1'b1;
                        w_sgn = 1'b1;
                        w_wb  = 1'b0;
                    end
                    6'h1B: begin
                        w_div = 1'b1;
                        w_wb  = 1'b0;
                    end
`endif
                    default: begin
                        w_ill = 1'b1;
                        w_wb  = 1'b0;
                    end
                endcase
            end
            6'h08: begin
                w_res = w_sumi;
                w_ovf = w_ovf_addi;
            end
            6'h09: w_res = w_sumi;
            6'h0A: w_res = WIDTH'($signed(w_a) < $signed(w_simm));
            6'h0B: w_res = WIDTH'(w_a < w_simm);
            6'h0C: w_res = w_a & w_zimm;
            6'h0D: w_res = w_a | w_zimm;
            6'h0E: w_res = w_a ^ w_zimm;
            6'h0F: w_res = w_lui;
            default: begin
                w_ill = 1'b1;
                w_wb  = 1'b0;
            end
        endcase
        if (w_ovf) w_wb = 1'b0;
    end

    // Result register: load on accept, post the long-op marker, drop on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wb_en     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept && !w_mul && !w_div) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_wb_en     <= w_wb;
            r_overflow  <= w_ovf;
            r_illegal   <= w_ill;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= '0;
            r_wb_en     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ALU_MULDIV_EN
    assign w_sa   = w_sgn & w_a[WIDTH-1];
    assign w_sb   = w_sgn & w_b[WIDTH-1];
    assign w_ma   = w_sa ? -w_a : w_a;
    assign w_mb   = w_sb ? -w_b : w_b;
    assign w_madd = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_op} : '0);
    assign w_drem = {r_wh, r_wl[WIDTH-1]};
    assign w_ddif = w_drem - {1'b0, r_op};
    assign w_prod = {w_nh, w_nl};
    assign w_last = ((r_state == MUL) || (r_state == DIV)) &&
                    (r_cnt == CW'(WIDTH - 1));
    assign w_in_ready = (r_state == IDLE) &&
                        (!r_out_valid || bus.out_ready);

    // One shift-add (MUL) or restoring shift-subtract (DIV) step.
    always_comb begin
        w_nh = r_wh;
        w_nl = r_wl;
        if (r_state == MUL) begin
            w_nh = w_madd[WIDTH:1];
            w_nl = {w_madd[0], r_wl[WIDTH-1:1]};
        end else if (r_state == DIV) begin
            w_nh = w_ddif[WIDTH] ? w_drem[WIDTH-1:0] : w_ddif[WIDTH-1:0];
            w_nl = {r_wl[WIDTH-2:0], ~w_ddif[WIDTH]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: long ops run WIDTH steps then pass through DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_mul)      w_next = MUL;
                else if (w_accept && w_div) w_next = DIV;
            end
            MUL, DIV: if (w_last) w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end

    // Operand magnitudes, step counter and sign-corrected HI/LO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wh   <= '0;
            r_wl   <= '0;
            r_op   <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_accept && (w_mul || w_div)) begin
                r_cnt <= '0;
                r_wh  <= '0;
                if (w_mul) begin
                    r_op   <= w_ma;
                    r_wl   <= w_mb;
                    r_qneg <= w_sa ^ w_sb;
                    r_rneg <= 1'b0;
                end else if (w_b == '0) begin
                    r_op   <= '0;
                    r_wl   <= w_a;
                    r_qneg <= 1'b0;
                    r_rneg <= 1'b0;
                end else begin
                    r_op   <= w_mb;
                    r_wl   <= w_ma;
                    r_qneg <= w_sa ^ w_sb;
                    r_rneg <= w_sa;
                end
            end else if ((r_state == MUL) || (r_state == DIV)) begin
                r_cnt <= r_cnt + CW'(1);
                r_wh  <= w_nh;
                r_wl  <= w_nl;
            end
            if (w_last && (r_state == MUL)) begin
                {r_hi, r_lo} <= r_qneg ? -w_prod : w_prod;
            end else if (w_last) begin
                r_lo <= r_qneg ? -w_nl : w_nl;
                r_hi <= r_rneg ? -w_nh : w_nh;
            end
        end
    end
`else
    assign w_last     = 1'b0;
    assign w_in_ready = !r_out_valid || bus.out_ready;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table plus scoreboard for alu_exec_unit.
// Mult/div sequences are exercised when ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;
    localparam int W  = 32;
    localparam int IW = 16;
    localparam int NV = 22;

    typedef struct {
        logic [5:0]    op;
        logic [5:0]    fn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [IW-1:0] imm;
        logic [W-1:0]  res;
        logic          wb;
        logic          ovf;
        logic          ill;
    } vec_t;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         wb;
        logic         ovf;
        logic         ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t m_e;
    vec_t vt[NV];

    alu_exec_unit_if #(.WIDTH(W), .IMM_W(IW)) bus ();

    alu_exec_unit #(.WIDTH(W), .IMM_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare every consumed result against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output res=%h", bus.result);
            end else begin
                m_e = sb.pop_front();
                if (bus.result !== m_e.res || bus.wb_en !== m_e.wb ||
                    bus.overflow !== m_e.ovf || bus.illegal !== m_e.ill) begin
                    errors++;
                    $display("FAIL out_id%0d got res=%h wb=%b ovf=%b ill=%b exp res=%h wb=%b ovf=%b ill=%b",
                             m_e.id, bus.result, bus.wb_en, bus.overflow,
                             bus.illegal, m_e.res, m_e.wb, m_e.ovf, m_e.ill);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [IW-1:0] im, input logic [W-1:0] res,
                         input logic wb, input logic ovf, input logic ill,
                         input int id);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.imm      = im;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout id=%0d in_ready=%b required 1",
                     id, bus.in_ready);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            e.id  = id;
            e.res = res;
            e.wb  = wb;
            e.ovf = ovf;
            e.ill = ill;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_MULDIV_EN
    task automatic muldiv(input logic [5:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hi,
                          input logic [W-1:0] lo, input int id);
        issue(6'h00, fn, a, b, '0, '0, 1'b0, 1'b0, 1'b0, id);
        issue(6'h00, 6'h10, '0, '0, '0, hi, 1'b1, 1'b0, 1'b0, id + 1);
        issue(6'h00, 6'h12, '0, '0, '0, lo, 1'b1, 1'b0, 1'b0, id + 2);
    endtask
`else
    logic [5:0] md_fn[6];
`endif

    initial begin
        int t0;
        int p;
        int n;
        logic busy_bad;

        vt[0]  = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{6'h00, 6'h23, 32'h0, 32'h1, 16'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 32'hF000F000, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{6'h00, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 16'h0, 32'hFFFFF0F0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{6'h00, 6'h26, 32'hFFFF0000, 32'h0F0F0F0F, 16'h0, 32'hF0F00F0F, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{6'h00, 6'h27, 32'hF0F0F0F0, 32'h0000FFFF, 16'h0, 32'h0F0F0000, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 32'h1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{6'h00, 6'h2B, 32'hFFFFFFFF, 32'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{6'h08, 6'h00, 32'h5, 32'h0, 16'hFFFF, 32'h4, 1'b1, 1'b0, 1'b0};
        vt[11] = '{6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h1, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[12] = '{6'h09, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h1, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vt[13] = '{6'h0D, 6'h00, 32'h0, 32'h0, 16'hFFFF, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};
        vt[14] = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8001, 32'h00008001, 1'b1, 1'b0, 1'b0};
        vt[15] = '{6'h0E, 6'h00, 32'h0000FFFF, 32'h0, 16'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0};
        vt[16] = '{6'h0F, 6'h00, 32'hDEADBEEF, 32'h0, 16'h1234, 32'h12340000, 1'b1, 1'b0, 1'b0};
        vt[17] = '{6'h0A, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h0, 32'h1, 1'b1, 1'b0, 1'b0};
        vt[18] = '{6'h0B, 6'h00, 32'h1, 32'h0, 16'hFFFF, 32'h1, 1'b1, 1'b0, 1'b0};
        vt[19] = '{6'h3F, 6'h00, 32'h12345678, 32'h9, 16'h55, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[20] = '{6'h00, 6'h3F, 32'h12345678, 32'h9, 16'h55, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[21] = '{6'h00, 6'h2A, 32'h1, 32'hFFFFFFFF, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.wb_en !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b res=%h wb=%b ovf=%b ill=%b required all 0",
                     bus.out_valid, bus.result, bus.wb_en, bus.overflow, bus.illegal);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;

        t0 = cyc;
        for (int i = 0; i < NV; i++) begin
            issue(vt[i].op, vt[i].fn, vt[i].a, vt[i].b, vt[i].imm,
                  vt[i].res, vt[i].wb, vt[i].ovf, vt[i].ill, i);
        end
        checks++;
        if (cyc - t0 != NV) begin
            errors++;
            $display("FAIL throughput cycles=%0d required %0d", cyc - t0, NV);
        end
        settle();

`ifdef ALU_MULDIV_EN
        issue(6'h00, 6'h18, 32'hFFFFFFFD, 32'h7, '0, '0, 1'b0, 1'b0, 1'b0, 200);
        p = 1;
        busy_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid || p > 200) break;
            if (bus.in_ready) busy_bad = 1'b1;
            p++;
        end
        checks++;
        if (p != W + 1) begin
            errors++;
            $display("FAIL mult_latency got %0d required %0d", p, W + 1);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL mult_busy in_ready went 1 required 0");
        end
        @(posedge clk);
        #1;
        issue(6'h00, 6'h10, '0, '0, '0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 201);
        issue(6'h00, 6'h12, '0, '0, '0, 32'hFFFFFFEB, 1'b1, 1'b0, 1'b0, 202);
        muldiv(6'h1A, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 210);
        muldiv(6'h1B, 32'h9, 32'h0, 32'h9, 32'hFFFFFFFF, 220);
        muldiv(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 230);
        muldiv(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 240);
        muldiv(6'h1A, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 250);
        muldiv(6'h1A, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 260);
        muldiv(6'h18, 32'h10000, 32'h10000, 32'h1, 32'h0, 270);
        muldiv(6'h1B, 32'hFFFFFFFF, 32'hA, 32'h5, 32'h19999999, 280);
`else
        md_fn = '{6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
        for (int i = 0; i < 6; i++) begin
            issue(6'h00, md_fn[i], 32'h5, 32'h3, '0, '0, 1'b0, 1'b0, 1'b1, 300 + i);
        end
`endif
        settle();

        bus.out_ready = 1'b0;
        issue(6'h00, 6'h24, 32'hFFFF0000, 32'h0F0F0F0F, '0,
              32'h0F0F0000, 1'b1, 1'b0, 1'b0, 100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h0F0F0000 ||
                bus.wb_en !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got v=%b res=%h wb=%b rdy=%b required 1 0f0f0000 1 0",
                         k, bus.out_valid, bus.result, bus.wb_en, bus.in_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        settle();

`ifdef ALU_MULDIV_EN
        issue(6'h00, 6'h1A, 32'd100, 32'd7, '0, '0, 1'b0, 1'b0, 1'b0, 400);
`else
        bus.out_ready = 1'b0;
        issue(6'h00, 6'h24, 32'hFFFFFFFF, 32'h1, '0, 32'h1, 1'b1, 1'b0, 1'b0, 400);
`endif
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset got v=%b rdy=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
`ifdef ALU_MULDIV_EN
        issue(6'h00, 6'h12, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 401);
        issue(6'h00, 6'h10, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 402);
`else
        issue(6'h00, 6'h21, 32'h1, 32'h2, '0, 32'h3, 1'b1, 1'b0, 1'b0, 401);
`endif

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
